// File: rtl/high_speed_out_bus.sv
// Transmit end of the four-phase bundled-data AER link: a small FIFO feeding a
// request/acknowledge handshake FSM, with acknowledge brought in through two flops.

module double_flop_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else if (enable) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

module high_speed_out_bus #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          request,
  input  logic                          acknowledge,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;
  logic                  ack_s;
  logic                  request_d;
  logic [DATA_WIDTH-1:0] out_data_d;

  double_flop_synchronizer #(.WIDTH(1)) u_ack_sync (
    .clk    (clk),
    .rst    (rst),
    .enable (1'b1),
    .d      (acknowledge),
    .q      (ack_s)
  );

  // Extra wrap bit on each pointer separates full from empty.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign fifo_count = wr_ptr - rd_ptr;
  assign busy       = (state_q != IDLE) || !empty;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      request  <= 1'b0;
      out_data <= '0;
    end else begin
      state_q  <= state_d;
      request  <= request_d;
      out_data <= out_data_d;
    end
  end

  // SETUP waits for ack_s low so a stale acknowledge after reset cannot start a transfer.
  always_comb begin
    state_d    = state_q;
    request_d  = request;
    out_data_d = out_data;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          out_data_d = mem[rd_ptr[AW-1:0]];
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (!ack_s) begin
          request_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          request_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        request_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_high_speed_out_bus.sv
// Bench for high_speed_out_bus: a remote receiver model drives acknowledge, a monitor
// watches the link rules, and each scenario task checks its own expectations.

module tb_high_speed_out_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        request;
  logic        acknowledge;
  logic        busy;
  logic [2:0]  fifo_count;

  int          tests = 0;
  int          fails = 0;

  logic [15:0] rx_q[$];
  logic [15:0] exp_q[$];
  bit          rx_en   = 1'b0;
  bit          rx_rand = 1'b0;
  int          ack_dly = 0;
  int          rel_dly = 0;

  int          cyc = 0;
  logic        ack_hist[8];
  logic        prev_req = 1'b0;
  logic [15:0] prev_data = '0;
  int          rise_cnt = 0;

  high_speed_out_bus #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .request     (request),
    .acknowledge (acknowledge),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Acknowledge as the design can see it: synchronizer flops hold 0 while rst is high.
  task automatic edge_recorder();
    forever begin
      @(posedge clk);
      cyc++;
      ack_hist[cyc % 8] = rst ? 1'b0 : acknowledge;
    end
  endtask

  task automatic link_monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_req && request) begin
          tests++;
          if (out_data !== prev_data) begin
            fails++;
            $display("FAIL data_stable: out_data=%h changed while request=1 (held %h) cyc=%0d", out_data, prev_data, cyc);
          end
        end
        if (request && !prev_req) begin
          rise_cnt++;
          if (cyc >= 2) begin
            tests++;
            if (ack_hist[(cyc - 2) % 8] !== 1'b0) begin
              fails++;
              $display("FAIL req_rise_ack: request rose with synced ack=%b required 0 cyc=%0d", ack_hist[(cyc - 2) % 8], cyc);
            end
          end
        end
      end
      prev_req  = request;
      prev_data = out_data;
    end
  endtask

  // Remote receiver: latch data on request, ack after a delay, release after request falls.
  task automatic receiver();
    int d;
    forever begin
      @(negedge clk);
      if (rx_en && request && !acknowledge) begin
        rx_q.push_back(out_data);
        d = rx_rand ? int'($urandom_range(10, 0)) : ack_dly;
        repeat (d) @(negedge clk);
        acknowledge = 1'b1;
        while (request) @(negedge clk);
        d = rx_rand ? int'($urandom_range(10, 0)) : rel_dly;
        repeat (d) @(negedge clk);
        acknowledge = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n && !busy && !acknowledge) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (request !== 1'b0 || out_data !== 16'h0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: req=%b data=%h cnt=%0d rdy=%b busy=%b required 0/0000/0/1/0",
               request, out_data, fifo_count, in_ready, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    rx_q.delete();
    rx_en = 1'b1; rx_rand = 1'b0; ack_dly = 3; rel_dly = 3;
    in_data = 16'hA5A5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (request !== 1'b0) begin
      fails++; $display("FAIL single_e0_req: request=%b required 0", request);
    end
    @(negedge clk);
    tests++;
    if (out_data !== 16'hA5A5 || request !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL single_e1: data=%h req=%b busy=%b cnt=%0d required a5a5/0/1/0", out_data, request, busy, fifo_count);
    end
    @(negedge clk);
    tests++;
    if (request !== 1'b1) begin
      fails++; $display("FAIL single_e2_req: request=%b required 1", request);
    end
    wait_done(1, ok);
    tests++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 16'hA5A5) begin
      fails++;
      $display("FAIL single_rx: ok=%b count=%0d word=%h required 1 word a5a5", ok, rx_q.size(), ok ? rx_q[0] : 16'hx);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0;
    rx_q.delete();
    r0 = rise_cnt;
    rx_en = 1'b1; rx_rand = 1'b0; ack_dly = 1; rel_dly = 0;
    for (int i = 1; i <= 3; i++) begin
      in_data = 16'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    // Word 1 left the FIFO for out_data one edge after it arrived.
    tests++;
    if (fifo_count !== 3'd2) begin
      fails++; $display("FAIL b2b_count: fifo_count=%0d required 2", fifo_count);
    end
    wait_done(3, ok);
    tests++;
    if (!ok || rx_q.size() != 3 || rx_q[0] !== 16'd1 || rx_q[1] !== 16'd2 || rx_q[2] !== 16'd3) begin
      fails++; $display("FAIL b2b_order: ok=%b count=%0d words=%p required 1,2,3", ok, rx_q.size(), rx_q);
    end
    tests++;
    if (rise_cnt - r0 != 3 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL b2b_cycles: request rises=%0d cnt=%0d required 3/0", rise_cnt - r0, fifo_count);
    end
  endtask

  task automatic test_fill();
    bit       ok;
    bit [5:0] acc;
    rx_q.delete();
    rx_en = 1'b0; acknowledge = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = 16'(16'h10 + i); in_valid = 1'b1;
      acc[i] = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (acc !== 6'b011111) begin
      fails++; $display("FAIL fill_accept: accepted mask=%b required 011111", acc);
    end
    tests++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || request !== 1'b1 || out_data !== 16'h10) begin
      fails++;
      $display("FAIL fill_state: cnt=%0d rdy=%b req=%b data=%h required 4/0/1/0010", fifo_count, in_ready, request, out_data);
    end
    rx_en = 1'b1; ack_dly = 2; rel_dly = 1;
    wait_done(5, ok);
    tests++;
    if (!ok || rx_q.size() != 5) begin
      fails++; $display("FAIL fill_count: ok=%b delivered=%0d required 5", ok, rx_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== 16'(16'h10 + i)) begin
        fails++; $display("FAIL fill_word%0d: got %h required %h", i, i < rx_q.size() ? rx_q[i] : 16'hx, 16'(16'h10 + i));
      end
    end
  endtask

  task automatic test_stale_ack();
    bit ok;
    bit seen_req;
    rx_q.delete();
    rx_en = 1'b0; acknowledge = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_data = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (request !== 1'b0) seen_req = 1'b1;
    end
    tests++;
    if (seen_req || out_data !== 16'h1234 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL stale_hold: req_seen=%b data=%h cnt=%0d required 0/1234/0", seen_req, out_data, fifo_count);
    end
    acknowledge = 1'b0;
    @(negedge clk);
    tests++;
    if (request !== 1'b0) begin
      fails++; $display("FAIL stale_e1: request=%b required 0", request);
    end
    @(negedge clk);
    tests++;
    if (request !== 1'b0) begin
      fails++; $display("FAIL stale_e2: request=%b required 0", request);
    end
    @(negedge clk);
    tests++;
    if (request !== 1'b1) begin
      fails++; $display("FAIL stale_e3: request=%b required 1", request);
    end
    rx_en = 1'b1; ack_dly = 1; rel_dly = 1;
    wait_done(1, ok);
    tests++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 16'h1234) begin
      fails++; $display("FAIL stale_rx: ok=%b count=%0d required one word 1234", ok, rx_q.size());
    end
  endtask

  task automatic test_reset_in_req();
    bit ok;
    rx_q.delete();
    rx_en = 1'b0; acknowledge = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(16'h21 + i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (request !== 1'b1 || fifo_count !== 3'd2) begin
      fails++; $display("FAIL rreq_pre: req=%b cnt=%0d required 1/2", request, fifo_count);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (request !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0) begin
      fails++;
      $display("FAIL rreq_async: req=%b cnt=%0d rdy=%b busy=%b data=%h required 0/0/1/0/0000",
               request, fifo_count, in_ready, busy, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_en = 1'b1; ack_dly = 0; rel_dly = 2;
    in_data = 16'h5A5A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(1, ok);
    tests++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 16'h5A5A) begin
      fails++; $display("FAIL rreq_after: ok=%b count=%0d words=%p required one word 5a5a", ok, rx_q.size(), rx_q);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    int cycles;
    int bad_cnt;
    rx_q.delete();
    exp_q.delete();
    rx_en = 1'b1; rx_rand = 1'b1;
    n = 0; cycles = 0; bad_cnt = 0;
    while (n < 1000 && cycles < 60000) begin
      in_valid = 1'($urandom_range(1, 0));
      in_data  = 16'($urandom);
      if (fifo_count > 3'd4 || (in_ready == 1'b0 && fifo_count != 3'd4)) bad_cnt++;
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        n++;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    tests++;
    if (n != 1000) begin
      fails++; $display("FAIL rand_accept: accepted %0d words required 1000 within budget", n);
    end
    tests++;
    if (bad_cnt != 0) begin
      fails++; $display("FAIL rand_count: %0d cycles with bad fifo_count/in_ready required 0", bad_cnt);
    end
    wait_done(exp_q.size(), ok);
    tests++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rand_total: ok=%b delivered=%0d required %0d", ok, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL rand_word%0d: got %h required %h", i, i < rx_q.size() ? rx_q[i] : 16'hx, exp_q[i]);
      end
    end
    rx_rand = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; acknowledge = 1'b0;
    for (int i = 0; i < 8; i++) ack_hist[i] = 1'b0;
    fork
      edge_recorder();
      link_monitor();
      receiver();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_stale_ack();
    test_reset_in_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
